neopixel_cmd_ctrl: RTL and testbench
====================================

# neopixel_cmd_ctrl

Pushbutton command sequencer for the NeoPixel LED controller. It consumes the already-synchronized KEY0 and SW[4:0] signals and debounces KEY0 presses and releases. On each debounced press it decodes one command from the switches. The decoded command either updates pixel/channel selection, writes one colour intensity into the downstream pixel buffer, or requests a frame transmission from the LED driver through a busy handshake.

## Interface

**Parameters**
- DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a press or release (1 ms at 50 MHz).
- NUM_PIXELS, default 5: number of addressable pixels; legal indices are 0..NUM_PIXELS-1 (at most 8).

**Ports**
- clock, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- syncedKEY0, input, 1: synchronized pushbutton, active-low (0 = pressed).
- syncedSW, input, 5: synchronized switches; [4:3] opcode, [2:0] argument.
- ledBusy, input, 1: driver is transmitting a frame.
- wrEn, output, 1: one-cycle pixel-buffer write strobe.
- wrAddr, output, 3: pixel index for the write.
- wrChannel, output, 2: colour channel for the write; 0 = G, 1 = R, 2 = B.
- wrData, output, 8: intensity value.
- sendStart, output, 1: one-cycle frame-start request.
- curPixel, output, 3: currently selected pixel.
- curChannel, output, 2: currently selected channel.
- cmdError, output, 1: the last executed command was illegal.

## Operation

- **Reset values:** FSM in IDLE, debounce counter 0, and every output is 0, including curPixel and curChannel. Reset asserted mid-operation aborts immediately. No wrEn or sendStart is emitted for the aborted command.
- **FSM states:** IDLE, DB_PRESS, EXECUTE, WAIT_SEND, WAIT_RELEASE, DB_RELEASE.
- **IDLE**
  - Key = 0: go to DB_PRESS with count = 1.
- **DB_PRESS**
  - Key = 1: return to IDLE (bounce), count cleared.
  - Key = 0 and count == DEBOUNCE_CYCLES: go to EXECUTE.
  - Otherwise increment count.
- **EXECUTE** lasts one cycle. syncedSW is sampled in this cycle only. Opcode decode:
  - 00 SELECT_PIXEL: if arg < NUM_PIXELS, curPixel <= arg and cmdError <= 0; else curPixel is unchanged and cmdError <= 1.
  - 01 SELECT_CHANNEL: if arg[1:0] != 3, curChannel <= arg[1:0] and cmdError <= 0; else curChannel is unchanged and cmdError <= 1. arg[2] is ignored.
  - 10 WRITE: wrEn pulses with wrAddr = curPixel, wrChannel = curChannel, wrData = {arg, arg, arg[2:1]}, so 0 maps to 0x00 and 7 maps to 0xFF. cmdError <= 0.
  - 11 SEND: if ledBusy = 0, sendStart pulses and cmdError <= 0; otherwise go to WAIT_SEND.
  - All opcodes except a busy SEND continue to WAIT_RELEASE.
- **WAIT_SEND:** holds until ledBusy = 0 is sampled, then pulses sendStart, clears cmdError, and goes to WAIT_RELEASE. Key activity is ignored while waiting.
- **WAIT_RELEASE**
  - Key = 1: go to DB_RELEASE with count = 1.
- **DB_RELEASE**
  - Key = 0: return to WAIT_RELEASE.
  - Key = 1 and count == DEBOUNCE_CYCLES: go to IDLE.
  - Otherwise increment count.
- **One command per press:** holding the key never re-executes.
- **Counter:** width is $clog2(DEBOUNCE_CYCLES+1). The counter saturates and never wraps.
- **Output hold:** wrAddr, wrChannel and wrData hold their last written values between writes.

## Timing

- **Registered outputs:** all outputs are registered; there are no combinational input-to-output paths.
- **Press latency:** let E0 be the first edge sampling key = 0 in IDLE. If the key stays 0 on edges E0..E(N), with N = DEBOUNCE_CYCLES, then EXECUTE occupies the cycle after E(N). wrEn or sendStart is high for exactly one cycle, the cycle after edge E(N+1). curPixel, curChannel and cmdError update on that same edge.
- **Send latency:** when ledBusy falls while in WAIT_SEND, sendStart rises one cycle after the first edge that samples ledBusy = 0. If ledBusy is already 0 in the EXECUTE cycle, sendStart is high in the cycle after EXECUTE.
- **Pulse width:** wrEn and sendStart are never high for two consecutive cycles.
- **Re-arm:** a new press is accepted no earlier than DEBOUNCE_CYCLES+1 cycles after key release begins.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4 and NUM_PIXELS = 5.

- **Reset check:** assert reset mid-DB_PRESS and mid-WAIT_SEND. All outputs go to 0 asynchronously, and no pulse follows deassertion.
- **Write command:** SW = 5'b00_011 press/release, then 5'b01_001 press/release, then 5'b10_111 held 6 cycles. Expect curPixel = 3, curChannel = 1, then a single wrEn with wrAddr = 3, wrChannel = 1, wrData = 0xFF. A write with arg = 0 gives wrData = 0x00; arg = 4 gives wrData = 0x92.
- **Bounce rejection:** key low 3 cycles, high 1, low 3, then high. No command executes. A 5-cycle low press executes exactly one command, at the latency given in Timing.
- **Illegal commands:** SW = 5'b00_110 sets cmdError = 1 with curPixel unchanged. SW = 5'b01_011 sets cmdError = 1 with curChannel unchanged. A following legal SELECT_PIXEL clears cmdError.
- **Send when busy:** ledBusy = 1, SW = 5'b11_000 press. No sendStart while busy, even if the key is released and pressed again. Drop ledBusy and expect exactly one sendStart one cycle later; the extra press is ignored.
- **Hold without repeat:** hold the key 100 cycles with SW = 10_010. Exactly one wrEn (data 0x49). The next press is accepted only after 5 consecutive high samples.

Source files
------------

// File: rtl/neopixel_cmd_ctrl.sv
// rtl/neopixel_cmd_ctrl.sv - debounced pushbutton command sequencer for the NeoPixel controller
// One command per debounced KEY0 press: select pixel/channel, write an intensity, or request a frame send.
module neopixel_cmd_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_PIXELS      = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       syncedKEY0,
  input  logic [4:0] syncedSW,
  input  logic       ledBusy,
  output logic       wrEn,
  output logic [2:0] wrAddr,
  output logic [1:0] wrChannel,
  output logic [7:0] wrData,
  output logic       sendStart,
  output logic [2:0] curPixel,
  output logic [1:0] curChannel,
  output logic       cmdError
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [3:0]    PIX_LIMIT = 4'(NUM_PIXELS);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] DB_PRESS     = 3'd1;
  localparam logic [2:0] EXECUTE      = 3'd2;
  localparam logic [2:0] WAIT_SEND    = 3'd3;
  localparam logic [2:0] WAIT_RELEASE = 3'd4;
  localparam logic [2:0] DB_RELEASE   = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] count;
  logic [1:0]    opcode;
  logic [2:0]    arg;

  assign opcode = syncedSW[4:3];
  assign arg    = syncedSW[2:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      wrEn       <= 1'b0;
      wrAddr     <= '0;
      wrChannel  <= '0;
      wrData     <= '0;
      sendStart  <= 1'b0;
      curPixel   <= '0;
      curChannel <= '0;
      cmdError   <= 1'b0;
    end else begin
      wrEn      <= 1'b0;
      sendStart <= 1'b0;
      case (state)
        IDLE: begin
          if (!syncedKEY0) begin
            state <= DB_PRESS;
            count <= CW'(1);
          end
        end
        DB_PRESS: begin
          if (syncedKEY0) begin
            state <= IDLE;
            count <= '0;
          end else if (count == CNT_MAX) begin
            state <= EXECUTE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        EXECUTE: begin
          state <= WAIT_RELEASE;
          case (opcode)
            2'b00: begin
              if ({1'b0, arg} < PIX_LIMIT) begin
                curPixel <= arg;
                cmdError <= 1'b0;
              end else begin
                cmdError <= 1'b1;
              end
            end
            2'b01: begin
              if (arg[1:0] != 2'd3) begin
                curChannel <= arg[1:0];
                cmdError   <= 1'b0;
              end else begin
                cmdError <= 1'b1;
              end
            end
            2'b10: begin
              // Replicating the 3-bit argument spreads 0..7 evenly over 0x00..0xFF.
              wrEn      <= 1'b1;
              wrAddr    <= curPixel;
              wrChannel <= curChannel;
              wrData    <= {arg, arg, arg[2:1]};
              cmdError  <= 1'b0;
            end
            default: begin
              if (!ledBusy) begin
                sendStart <= 1'b1;
                cmdError  <= 1'b0;
              end else begin
                state <= WAIT_SEND;
              end
            end
          endcase
        end
        WAIT_SEND: begin
          if (!ledBusy) begin
            sendStart <= 1'b1;
            cmdError  <= 1'b0;
            state     <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (syncedKEY0) begin
            state <= DB_RELEASE;
            count <= CW'(1);
          end
        end
        DB_RELEASE: begin
          if (!syncedKEY0) begin
            state <= WAIT_RELEASE;
            count <= '0;
          end else if (count == CNT_MAX) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_cmd_ctrl.sv
// tb/tb_neopixel_cmd_ctrl.sv - scoreboard bench for neopixel_cmd_ctrl
// Expected write/send events are queued when a press is driven and checked when the strobes fire.
module tb_neopixel_cmd_ctrl;

  localparam int DB = 4;
  localparam int NP = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       syncedKEY0 = 1'b1;
  logic [4:0] syncedSW = '0;
  logic       ledBusy = 1'b0;
  logic       wrEn;
  logic [2:0] wrAddr;
  logic [1:0] wrChannel;
  logic [7:0] wrData;
  logic       sendStart;
  logic [2:0] curPixel;
  logic [1:0] curChannel;
  logic       cmdError;

  neopixel_cmd_ctrl #(.DEBOUNCE_CYCLES(DB), .NUM_PIXELS(NP)) dut (
    .clock(clock), .reset(reset), .syncedKEY0(syncedKEY0), .syncedSW(syncedSW),
    .ledBusy(ledBusy), .wrEn(wrEn), .wrAddr(wrAddr), .wrChannel(wrChannel),
    .wrData(wrData), .sendStart(sendStart), .curPixel(curPixel),
    .curChannel(curChannel), .cmdError(cmdError)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       isSend;
    logic [2:0] addr;
    logic [1:0] chan;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  cmpCount = 0;
  int  errCount = 0;
  logic [2:0] mPix = '0;
  logic [1:0] mChan = '0;
  logic       mErr = 1'b0;
  logic       prevWr = 1'b0;
  logic       prevSend = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] expData(input logic [2:0] a);
    int v;
    v = (int'(a) * 73) >> 1;
    return v[7:0];
  endfunction

  task automatic pushWrite(input logic [2:0] a, input int at);
    ev_t e;
    e.isSend = 1'b0; e.addr = mPix; e.chan = mChan; e.data = expData(a); e.cyc = at;
    sbq.push_back(e);
  endtask

  task automatic pushSend(input int at);
    ev_t e;
    e.isSend = 1'b1; e.addr = '0; e.chan = '0; e.data = '0; e.cyc = at;
    sbq.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (wrEn || sendStart) begin
        if (sbq.size() == 0) begin
          check("unexpectedPulse", {30'd0, wrEn, sendStart}, 32'd0);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          check("pulseKind", {31'd0, sendStart}, {31'd0, e.isSend});
          if (!e.isSend) check("wrFields", {19'd0, wrAddr, wrChannel, wrData}, {19'd0, e.addr, e.chan, e.data});
          check("pulseCycle", cyc, e.cyc);
        end
      end
      if (wrEn) check("wrWidth", {31'd0, prevWr}, 32'd0);
      if (sendStart) check("sendWidth", {31'd0, prevSend}, 32'd0);
    end
    prevWr = wrEn;
    prevSend = sendStart;
  end

  task automatic checkState(input string tag);
    check(tag, {26'd0, curPixel, curChannel, cmdError}, {26'd0, mPix, mChan, mErr});
  endtask

  task automatic checkAllZero(input string tag);
    check(tag, {12'd0, wrEn, wrAddr, wrChannel, wrData, sendStart, curPixel, curChannel, cmdError}, 32'd0);
  endtask

  // Drives one press of lowCycles sampled-low edges; when modeled, updates the reference model.
  task automatic pressCmd(input logic [4:0] sw, input int lowCycles, input bit modeled);
    logic [2:0] a;
    a = sw[2:0];
    @(posedge clock); #1;
    syncedSW = sw;
    syncedKEY0 = 1'b0;
    if (modeled) begin
      case (sw[4:3])
        2'b00: if (int'(a) < NP) begin mPix = a; mErr = 1'b0; end else mErr = 1'b1;
        2'b01: if (a[1:0] != 2'd3) begin mChan = a[1:0]; mErr = 1'b0; end else mErr = 1'b1;
        2'b10: begin pushWrite(a, cyc + DB + 2); mErr = 1'b0; end
        default: if (!ledBusy) begin pushSend(cyc + DB + 2); mErr = 1'b0; end
      endcase
    end
    repeat (lowCycles) @(posedge clock);
    #1 syncedKEY0 = 1'b1;
    repeat (DB + 4) @(posedge clock);
    #1;
    checkState("stateAfterPress");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 checkAllZero("resetValues");
    reset = 1'b0;
    repeat (2) @(posedge clock);

    check("dataMap7", {24'd0, expData(3'd7)}, 32'hFF);
    check("dataMap4", {24'd0, expData(3'd4)}, 32'h92);

    pressCmd(5'b00_011, 6, 1);
    pressCmd(5'b01_001, 6, 1);
    pressCmd(5'b10_111, 6, 1);
    pressCmd(5'b10_000, 6, 1);
    pressCmd(5'b10_100, 6, 1);

    // Two short bounces, then a minimum-length press
    @(posedge clock); #1;
    syncedSW = 5'b00_010;
    syncedKEY0 = 1'b0;
    repeat (3) @(posedge clock);
    #1 syncedKEY0 = 1'b1;
    @(posedge clock);
    #1 syncedKEY0 = 1'b0;
    repeat (3) @(posedge clock);
    #1 syncedKEY0 = 1'b1;
    repeat (8) @(posedge clock);
    #1 checkState("bounceNoCmd");
    pressCmd(5'b10_001, DB + 1, 1);

    pressCmd(5'b00_110, 6, 1);
    pressCmd(5'b00_101, 6, 1);
    pressCmd(5'b00_100, 6, 1);
    pressCmd(5'b01_011, 6, 1);
    pressCmd(5'b00_001, 6, 1);

    // Long hold, short re-press rejected, then a press exactly at re-arm
    @(posedge clock); #1;
    syncedSW = 5'b10_010;
    syncedKEY0 = 1'b0;
    pushWrite(3'd2, cyc + DB + 2);
    repeat (100) @(posedge clock);
    #1 syncedKEY0 = 1'b1;
    repeat (DB) @(posedge clock);
    #1 syncedKEY0 = 1'b0;
    repeat (10) @(posedge clock);
    #1 syncedKEY0 = 1'b1;
    repeat (DB + 1) @(posedge clock);
    #1 syncedKEY0 = 1'b0;
    pushWrite(3'd2, cyc + DB + 2);
    repeat (6) @(posedge clock);
    #1 syncedKEY0 = 1'b1;
    repeat (8) @(posedge clock);
    #1 checkState("afterHold");

    // Busy send with an extra press that must be ignored
    ledBusy = 1'b1;
    mErr = 1'b1;
    pressCmd(5'b00_111, 6, 1);
    pressCmd(5'b11_000, 6, 1);
    pressCmd(5'b11_000, 6, 0);
    repeat (5) @(posedge clock);
    #1 ledBusy = 1'b0;
    pushSend(cyc + 1);
    mErr = 1'b0;
    repeat (10) @(posedge clock);
    #1 checkState("afterBusySend");
    pressCmd(5'b11_000, 6, 1);

    // Reset in the middle of a press debounce
    @(posedge clock); #1;
    syncedSW = 5'b10_111;
    syncedKEY0 = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    syncedKEY0 = 1'b1;
    #1 checkAllZero("resetMidPress");
    mPix = '0; mChan = '0; mErr = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (12) @(posedge clock);
    #1 checkState("afterResetPress");

    // Reset while parked in the busy-send wait
    pressCmd(5'b00_010, 6, 1);
    ledBusy = 1'b1;
    @(posedge clock); #1;
    syncedSW = 5'b11_000;
    syncedKEY0 = 1'b0;
    repeat (6) @(posedge clock);
    #1 syncedKEY0 = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1 checkAllZero("resetMidWaitSend");
    mPix = '0; mChan = '0; mErr = 1'b0;
    ledBusy = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (12) @(posedge clock);
    #1 checkState("afterResetSend");

    repeat (10) @(posedge clock);
    check("sbEmpty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
